// File: rtl/floor_request_encoder.sv
// floor_request_encoder
// Latches one-hot floor-button requests and runs a SCAN (keep-direction)
// policy. Presents one encoded objective floor plus a valid flag to the car's
// control unit. The dir output is the FSM state register itself.
module floor_request_encoder #(
   parameter int FLOORS = 10,
   parameter int FW     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLOORS-1:0] buttons,
   input  logic [FW-1:0]     current,
   input  logic              arrived,
   output logic [FW-1:0]     obj,
   output logic              valid,
   output logic [FLOORS-1:0] pending,
   output logic [1:0]        dir
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_UP   = 2'b01;
   localparam logic [1:0] ST_DOWN = 2'b10;

   // One extra bit so the bound still fits when FLOORS == 2**FW.
   localparam logic [FW:0] FLOORS_W = (FW+1)'(FLOORS);

   logic [FLOORS-1:0] pending_q, pending_d;
   logic [1:0]        dir_q, dir_d;
   logic [FW-1:0]     obj_q, obj_d;
   logic              valid_q, valid_d;

   logic              cur_ok;
   logic [FLOORS-1:0] clr;
   logic              have_a, have_b;
   logic [FW-1:0]     min_a, max_b, nearest;

   assign cur_ok = ({1'b0, current} < FLOORS_W);

   // Pending update: OR in presses, then clear the served floor (clear wins).
   always_comb begin
      clr = '0;
      for (int i = 0; i < FLOORS; i++) begin
         clr[i] = arrived && cur_ok && (current == FW'(i));
      end
      pending_d = (pending_q | buttons) & ~clr;
   end

   // Scan next_pending: lowest request at/above the car, highest at/below it,
   // and the nearest of the two (ties go to the upper floor).
   always_comb begin
      have_a = 1'b0;
      have_b = 1'b0;
      min_a  = '0;
      max_b  = '0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (pending_d[i] && (FW'(i) >= current)) begin
            have_a = 1'b1;
            min_a  = FW'(i);
         end
      end
      for (int i = 0; i < FLOORS; i++) begin
         if (pending_d[i] && (FW'(i) <= current)) begin
            have_b = 1'b1;
            max_b  = FW'(i);
         end
      end
      if (have_a && have_b) begin
         nearest = ((min_a - current) <= (current - max_b)) ? min_a : max_b;
      end else if (have_a) begin
         nearest = min_a;
      end else begin
         nearest = max_b;
      end
   end

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending_q <= '0;
         dir_q     <= ST_IDLE;
         obj_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         dir_q     <= dir_d;
         obj_q     <= obj_d;
         valid_q   <= valid_d;
      end
   end

   // Next-state: keep travelling while requests remain ahead; an invalid
   // current floor freezes the FSM.
   always_comb begin
      dir_d = dir_q;
      if (!cur_ok) begin
         dir_d = dir_q;
      end else if (pending_d == '0) begin
         dir_d = ST_IDLE;
      end else begin
         case (dir_q)
            ST_IDLE: dir_d = (nearest >= current) ? ST_UP : ST_DOWN;
            ST_UP:   dir_d = have_a ? ST_UP : ST_DOWN;
            ST_DOWN: dir_d = have_b ? ST_DOWN : ST_UP;
            default: dir_d = ST_IDLE;
         endcase
      end
   end

   // Output decode: heading up always targets min(A), heading down max(B);
   // going idle keeps the last objective but drops valid.
   always_comb begin
      obj_d   = obj_q;
      valid_d = valid_q;
      if (cur_ok) begin
         if (dir_d == ST_UP) begin
            obj_d   = min_a;
            valid_d = 1'b1;
         end else if (dir_d == ST_DOWN) begin
            obj_d   = max_b;
            valid_d = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   assign pending = pending_q;
   assign dir     = dir_q;
   assign obj     = obj_q;
   assign valid   = valid_q;

endmodule

// File: tb/tb_floor_request_encoder.sv
// Directed bench for floor_request_encoder: hand-computed expectations are
// queued, then compared field by field after each clock edge.
module tb_floor_request_encoder;

   localparam int FLOORS = 10;
   localparam int FW     = 4;
   localparam int EW     = FLOORS + 1 + FW + 2;

   localparam logic [1:0] D_IDLE = 2'b00;
   localparam logic [1:0] D_UP   = 2'b01;
   localparam logic [1:0] D_DOWN = 2'b10;

   logic              clk = 1'b0;
   logic              reset;
   logic [FLOORS-1:0] buttons;
   logic [FW-1:0]     current;
   logic              arrived;
   logic [FW-1:0]     obj;
   logic              valid;
   logic [FLOORS-1:0] pending;
   logic [1:0]        dir;

   int n_checks = 0;
   int n_pass   = 0;

   // Expected {pending, valid, obj, dir}
   logic [EW-1:0] exp_q[$];

   // Clock
   always #5 clk = ~clk;

   floor_request_encoder #(.FLOORS(FLOORS), .FW(FW)) dut (
      .clk     (clk),
      .reset   (reset),
      .buttons (buttons),
      .current (current),
      .arrived (arrived),
      .obj     (obj),
      .valid   (valid),
      .pending (pending),
      .dir     (dir)
   );

   // Driver tasks
   task automatic drive(input logic r, input logic [FLOORS-1:0] b,
                        input logic [FW-1:0] c, input logic a);
      reset   = r;
      buttons = b;
      current = c;
      arrived = a;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard
   task automatic expect_out(input logic [FLOORS-1:0] p, input logic v,
                             input logic [FW-1:0] o, input logic [1:0] d);
      exp_q.push_back({p, v, o, d});
   endtask

   task automatic check_field(input string tag, input string field,
                              input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, observed, expected);
   endtask

   task automatic check_out(input string tag);
      logic [EW-1:0] e;
      e = exp_q.pop_front();
      check_field(tag, "pending", 32'(pending), 32'(e[EW-1 -: FLOORS]));
      check_field(tag, "valid",   32'(valid),   32'(e[FW+2]));
      check_field(tag, "obj",     32'(obj),     32'(e[FW+1:2]));
      check_field(tag, "dir",     32'(dir),     32'(e[1:0]));
   endtask

   // Directed sequence
   initial begin
      // Reset held two cycles with every button pressed
      drive(1'b1, 10'h3FF, 4'd0, 1'b0);
      tick();
      tick();
      expect_out(10'h000, 1'b0, 4'd0, D_IDLE);
      check_out("reset");

      drive(1'b0, 10'h000, 4'd0, 1'b0);
      tick();
      expect_out(10'h000, 1'b0, 4'd0, D_IDLE);
      check_out("reset_release");

      // Single call to floor 9 from floor 0
      drive(1'b0, 10'h200, 4'd0, 1'b0);
      tick();
      expect_out(10'h200, 1'b1, 4'd9, D_UP);
      check_out("single_call");
      drive(1'b0, 10'h000, 4'd0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
         expect_out(10'h200, 1'b1, 4'd9, D_UP);
         check_out("single_stable");
      end

      // Serve floor 9: empties, obj keeps last value
      drive(1'b0, 10'h000, 4'd9, 1'b1);
      tick();
      expect_out(10'h000, 1'b0, 4'd9, D_IDLE);
      check_out("serve_9");

      // Direction sweep: car at 5 heading up to 7, then 2 requested behind
      drive(1'b0, 10'h080, 4'd5, 1'b0);
      tick();
      expect_out(10'h080, 1'b1, 4'd7, D_UP);
      check_out("sweep_up7");
      drive(1'b0, 10'h004, 4'd5, 1'b0);
      tick();
      expect_out(10'h084, 1'b1, 4'd7, D_UP);
      check_out("sweep_add2");
      drive(1'b0, 10'h000, 4'd7, 1'b1);
      tick();
      expect_out(10'h004, 1'b1, 4'd2, D_DOWN);
      check_out("sweep_arrive7");
      drive(1'b0, 10'h000, 4'd2, 1'b1);
      tick();
      expect_out(10'h000, 1'b0, 4'd2, D_IDLE);
      check_out("sweep_arrive2");

      // Tie break at floor 4 between 2 and 6: upper wins
      drive(1'b0, 10'h044, 4'd4, 1'b0);
      tick();
      expect_out(10'h044, 1'b1, 4'd6, D_UP);
      check_out("tie_break");
      // Request behind the car waits
      drive(1'b0, 10'h008, 4'd4, 1'b0);
      tick();
      expect_out(10'h04C, 1'b1, 4'd6, D_UP);
      check_out("keep_dir");
      drive(1'b0, 10'h000, 4'd6, 1'b1);
      tick();
      expect_out(10'h00C, 1'b1, 4'd3, D_DOWN);
      check_out("reverse_at6");
      drive(1'b0, 10'h000, 4'd3, 1'b1);
      tick();
      expect_out(10'h004, 1'b1, 4'd2, D_DOWN);
      check_out("down_to2");
      drive(1'b0, 10'h000, 4'd2, 1'b1);
      tick();
      expect_out(10'h000, 1'b0, 4'd2, D_IDLE);
      check_out("down_done");

      // Clear priority over simultaneous press of the same floor
      drive(1'b0, 10'h008, 4'd2, 1'b0);
      tick();
      expect_out(10'h008, 1'b1, 4'd3, D_UP);
      check_out("clr_setup");
      drive(1'b0, 10'h008, 4'd3, 1'b1);
      tick();
      expect_out(10'h000, 1'b0, 4'd3, D_IDLE);
      check_out("clr_wins");
      drive(1'b0, 10'h008, 4'd3, 1'b0);
      tick();
      expect_out(10'h008, 1'b1, 4'd3, D_UP);
      check_out("own_floor");
      drive(1'b0, 10'h000, 4'd3, 1'b1);
      tick();
      expect_out(10'h000, 1'b0, 4'd3, D_IDLE);
      check_out("own_served");

      // Mid-operation reset with a button held
      drive(1'b0, 10'h102, 4'd5, 1'b0);
      tick();
      expect_out(10'h102, 1'b1, 4'd8, D_UP);
      check_out("multi_press");
      drive(1'b1, 10'h020, 4'd5, 1'b0);
      tick();
      expect_out(10'h000, 1'b0, 4'd0, D_IDLE);
      check_out("mid_reset");
      drive(1'b0, 10'h020, 4'd5, 1'b0);
      tick();
      expect_out(10'h020, 1'b1, 4'd5, D_UP);
      check_out("after_reset");

      // Invalid current floor: arrived ignored, presses still latch, FSM holds
      drive(1'b0, 10'h000, 4'd12, 1'b1);
      tick();
      expect_out(10'h020, 1'b1, 4'd5, D_UP);
      check_out("invalid_arrive");
      drive(1'b0, 10'h001, 4'd12, 1'b0);
      tick();
      expect_out(10'h021, 1'b1, 4'd5, D_UP);
      check_out("invalid_press");
      drive(1'b0, 10'h000, 4'd0, 1'b0);
      tick();
      expect_out(10'h021, 1'b1, 4'd0, D_UP);
      check_out("valid_again");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/floor_request_encoder.md
Name: floor_request_encoder

Overview:
- Inverse of the per-car floor decoder (floor number → one-hot `inside` lines).
- Accepts one-hot floor-button lines and latches them as pending requests.
- Runs a SCAN (keep-direction) policy and presents one encoded 4-bit objective floor, plus a valid flag, to the car's control unit.
- One instance per car; sits between the car's button panel and controlUnit's objective input.

Parameters:
- FLOORS, 10, number of floors / width of button and pending vectors (floors 0..FLOORS-1).
- FW, 4, width of floor-number fields; must satisfy 2^FW >= FLOORS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- buttons  input  FLOORS  one-hot-or-more request lines; level-sensitive, may be held many cycles.
- current  input  FW  car's present floor (counter output).
- arrived  input  1  one-cycle pulse: car stopped and served floor `current`.
- obj  output  FW  encoded target floor for the controller.
- valid  output  1  obj is meaningful (at least one request pending).
- pending  output  FLOORS  latched request vector.
- dir  output  2  FSM state: 00 IDLE, 01 UP, 10 DOWN.

Behaviour:
- Reset, applied on any clock edge with reset=1: pending=0, dir=IDLE, obj=0, valid=0. `buttons` is ignored during reset; mid-operation reset discards all requests.
- Current-floor validity:
  - current < FLOORS: valid.
  - current >= FLOORS: invalid. `arrived` is ignored; pending still ORs in buttons; dir, obj, valid hold.
- Pending update each edge: next_pending = (pending | buttons) & ~clr.
  - clr = one-hot(current) when arrived=1 and current is valid; otherwise 0.
  - Clear wins over a simultaneous press of the same floor.
- All outputs are registered and computed from next_pending and current. Latency: button press → valid/obj = 1 clock.
- Let A = pending floors >= current, B = pending floors <= current.
- FSM transitions and targets:
  - next_pending == 0, from any state: go IDLE, valid=0, obj holds last value.
  - IDLE with requests: target is the pending floor nearest to current. On equal distance the upper floor wins. Next state is UP if target >= current, else DOWN.
  - UP: if A is non-empty, target = min(A), stay UP. Else target = max(B), go DOWN.
  - DOWN: if B is non-empty, target = max(B), stay DOWN. Else target = min(A), go UP.
- Whenever the next state is UP or DOWN: valid=1, obj=target.
- A request at the car's own floor with arrived=0 becomes the target (obj=current). The controller opens the door, asserts arrived, and the request clears.
- The FSM never oscillates while requests remain in the travel direction. New requests behind the car wait until the direction is exhausted.
- obj always < FLOORS whenever valid=1.
- Multiple simultaneous button bits are all latched in the same cycle.

Test Plan:
- Reset: reset=1 for 2 cycles with buttons=10'h3FF → pending=0, valid=0, obj=0, dir=00. Release reset with buttons=0 → outputs unchanged.
- Single call: current=0, buttons bit 9 pulsed 1 cycle → next edge pending=10'b1000000000, valid=1, obj=9, dir=01. State stable for 20 cycles with no further input.
- Direction sweep: current=5, dir=UP, pending={2,7} → obj=7.
  - current=7, arrived → pending={2}, dir=10, obj=2.
  - current=2, arrived → pending=0, valid=0, dir=00.
- Tie break: IDLE, current=4, buttons bits 2 and 6 in same cycle → obj=6, dir=01.
- Clear priority: pending bit 3 set, current=3, arrived=1 and buttons bit 3 high same cycle → bit 3 cleared, valid=0.
  - Hold bit 3 next cycle with arrived=0 → re-latched, obj=3, valid=1.
- Mid-operation reset and invalid floor:
  - pending={1,8}, reset=1 one cycle with buttons bit 5 held → all cleared, bit 5 not latched. After reset, bit 5 latches next cycle.
  - current=12 with arrived=1 → pending unchanged.
